// File: rtl/pong_pkg.sv
// pong_pkg
// Shared types and constants for the Pong codebase.
//   pack_state_t : power-pack controller FSM state encoding (also exported
//                  on the controller's state_dbg port)
//   H_ACTIVE / V_ACTIVE : visible screen size in pixels
//   *_DEF        : default sprite sizes used as parameter defaults
package pong_pkg;

  localparam int H_ACTIVE      = 1024;
  localparam int V_ACTIVE      = 768;

  localparam int PACK_W_DEF    = 20;
  localparam int PACK_H_DEF    = 20;
  localparam int BALL_SIZE_DEF = 16;

  // The encoding is visible on state_dbg, so the values are pinned.
  typedef enum logic [1:0] {
    WAIT   = 2'd0,
    SPAWN  = 2'd1,
    ARMED  = 2'd2,
    EFFECT = 2'd3
  } pack_state_t;

endpackage

// File: rtl/rect_overlap.sv
// rect_overlap
// Combinational axis-aligned bounding-box overlap test between rectangle A
// and rectangle B, both given by their top-left corner.
//   Parameters : A_W/A_H, B_W/B_H rectangle sizes in pixels
//   a_x, a_y   : rectangle A top-left (11-bit x, 10-bit y)
//   b_x, b_y   : rectangle B top-left (11-bit x, 10-bit y)
//   hit        : high when the rectangles share at least one pixel;
//                edges that only touch do not count
module rect_overlap
  import pong_pkg::*;
#(
  parameter int A_W = BALL_SIZE_DEF,
  parameter int A_H = BALL_SIZE_DEF,
  parameter int B_W = PACK_W_DEF,
  parameter int B_H = PACK_H_DEF
) (
  input  logic [10:0] a_x,
  input  logic [9:0]  a_y,
  input  logic [10:0] b_x,
  input  logic [9:0]  b_y,
  output logic        hit
);

  // Everything is widened to 12 bits so position + size can never wrap
  // back to a small value near the right/bottom of the coordinate range.
  logic [11:0] ax, ay, bx, by;

  assign ax = {1'b0, a_x};
  assign ay = {2'b00, a_y};
  assign bx = {1'b0, b_x};
  assign by = {2'b00, b_y};

  assign hit = (ax < bx + 12'(B_W)) &&
               (ax + 12'(A_W) > bx) &&
               (ay < by + 12'(B_H)) &&
               (ay + 12'(A_H) > by);

endmodule

// File: rtl/power_pack_ctrl.sv
// power_pack_ctrl
// Drives the power-pack's spawn/eaten inputs: waits SPAWN_DELAY frames,
// spawns the pack, watches for the ball overlapping it once per frame, then
// runs an EFFECT_FRAMES long power-up window before starting over.
// Optional feature macro: POWER_PACK_TIMEOUT_EN -- an uneaten pack is
// withdrawn after TIMEOUT_FRAMES frames (a hit on the same frame wins).
// Ports:
//   clk            system/pixel clock
//   reset          asynchronous, active-low reset
//   game_en        high = game running; low freezes counters and detection
//   hcount/vcount  current raster position; (0,0) marks a new frame
//   ball_x/ball_y  ball top-left
//   pack_x/pack_y  pack top-left
//   spawn          one-cycle pulse placing the pack
//   eaten          high while the pack is consumed/parked
//   effect_active  power-up effect enabled
//   effect_left    frames of effect remaining
//   state_dbg      current FSM state encoding
module power_pack_ctrl
  import pong_pkg::*;
#(
  parameter int PACK_W         = PACK_W_DEF,
  parameter int PACK_H         = PACK_H_DEF,
  parameter int BALL_SIZE      = BALL_SIZE_DEF,
  parameter int SPAWN_DELAY    = 120,
  parameter int EFFECT_FRAMES  = 300,
  parameter int TIMEOUT_FRAMES = 600
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        game_en,
  input  logic [10:0] hcount,
  input  logic [9:0]  vcount,
  input  logic [10:0] ball_x,
  input  logic [9:0]  ball_y,
  input  logic [10:0] pack_x,
  input  logic [9:0]  pack_y,
  output logic        spawn,
  output logic        eaten,
  output logic        effect_active,
  output logic [8:0]  effect_left,
  output logic [1:0]  state_dbg
);

  // Frame counts share one 16-bit counter, so the frame parameters are
  // bounded to that range; effect_left is 9 bits wide.
  if (SPAWN_DELAY < 1 || SPAWN_DELAY > 65536) begin : g_bad_spawn_delay
    $error("power_pack_ctrl: SPAWN_DELAY must be in 1..65536");
  end
  if (EFFECT_FRAMES < 0 || EFFECT_FRAMES > 511) begin : g_bad_effect_frames
    $error("power_pack_ctrl: EFFECT_FRAMES must fit in 9 bits");
  end
  if (TIMEOUT_FRAMES < 1 || TIMEOUT_FRAMES > 65536) begin : g_bad_timeout
    $error("power_pack_ctrl: TIMEOUT_FRAMES must be in 1..65536");
  end

  localparam logic [15:0] DELAY_LAST  = 16'(SPAWN_DELAY - 1);
  localparam logic [8:0]  EFFECT_INIT = 9'(EFFECT_FRAMES);
`ifdef POWER_PACK_TIMEOUT_EN
  localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT_FRAMES - 1);
`endif

  pack_state_t state, state_next;
  logic [15:0] frame_cnt, frame_cnt_next;
  logic [8:0]  left_q, left_next;
  logic        frame_tick;
  logic        hit;

  // Frozen frames never produce a tick, so an overlap seen while game_en
  // is low is simply dropped instead of being remembered.
  assign frame_tick = game_en && (hcount == 11'd0) && (vcount == 10'd0);

  rect_overlap #(
    .A_W (BALL_SIZE),
    .A_H (BALL_SIZE),
    .B_W (PACK_W),
    .B_H (PACK_H)
  ) u_overlap (
    .a_x (ball_x),
    .a_y (ball_y),
    .b_x (pack_x),
    .b_y (pack_y),
    .hit (hit)
  );

  // State and counters; reset parks the pack and kills any running effect
  // without waiting for a clock edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= WAIT;
      frame_cnt <= '0;
      left_q    <= '0;
    end else begin
      state     <= state_next;
      frame_cnt <= frame_cnt_next;
      left_q    <= left_next;
    end
  end

  // Next-state logic and state-decoded outputs. frame_cnt is reused as the
  // ARMED timeout counter; it is always zero on entry to ARMED because the
  // WAIT->SPAWN transition clears it.
  always_comb begin
    state_next     = state;
    frame_cnt_next = frame_cnt;
    left_next      = left_q;
    spawn          = 1'b0;
    eaten          = 1'b1;
    effect_active  = 1'b0;

    case (state)
      WAIT: begin
        if (frame_tick) begin
          if (frame_cnt == DELAY_LAST) begin
            state_next     = SPAWN;
            frame_cnt_next = '0;
          end else begin
            frame_cnt_next = frame_cnt + 16'd1;
          end
        end
      end

      SPAWN: begin
        spawn      = 1'b1;
        eaten      = 1'b0;
        state_next = ARMED;
      end

      ARMED: begin
        eaten = 1'b0;
        if (frame_tick) begin
          if (hit) begin
            state_next     = EFFECT;
            left_next      = EFFECT_INIT;
            frame_cnt_next = '0;
          end
`ifdef POWER_PACK_TIMEOUT_EN
          else if (frame_cnt == TIMEOUT_LAST) begin
            state_next     = WAIT;
            frame_cnt_next = '0;
          end else begin
            frame_cnt_next = frame_cnt + 16'd1;
          end
`endif
        end
      end

      EFFECT: begin
        effect_active = 1'b1;
        if (frame_tick) begin
          if (left_q <= 9'd1) begin
            left_next  = '0;
            state_next = WAIT;
          end else begin
            left_next = left_q - 9'd1;
          end
        end
      end

      default: state_next = WAIT;
    endcase
  end

  assign effect_left = left_q;
  assign state_dbg   = state;

endmodule
